// File: rtl/dp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dp_ctrl_pkg
// Description : Shared types and encodings for the datapath sequencer:
//               FSM state enum, command opcodes, ALU and shifter codes,
//               writeback-mux selects and the captured-command record.
// Revision    : 1.0 - initial release
// ============================================================================
package dp_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_EXEC   = 3'd3,
        S_WB_C   = 3'd4,
        S_WB_IMM = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    // Command opcodes; 4..7 are illegal
    localparam logic [2:0] OP_MOV_IMM = 3'd0;
    localparam logic [2:0] OP_MOV     = 3'd1;
    localparam logic [2:0] OP_ALU     = 3'd2;
    localparam logic [2:0] OP_CMP     = 3'd3;

    // ALU selects
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_NOT = 2'd3;

    // Shifter selects
    localparam logic [1:0] SHIFT_NONE = 2'd0;
    localparam logic [1:0] SHIFT_LSL1 = 2'd1;
    localparam logic [1:0] SHIFT_LSR1 = 2'd2;
    localparam logic [1:0] SHIFT_ASR1 = 2'd3;

    // Writeback mux selects
    localparam logic VSEL_C   = 1'b0;
    localparam logic VSEL_IMM = 1'b1;

    // Captured command fields other than the immediate
    typedef struct packed {
        logic [2:0] op;
        logic [2:0] rd;
        logic [2:0] rn;
        logic [2:0] rm;
        logic [1:0] alu;
        logic [1:0] shift;
    } cmd_fields_t;

    localparam int CMD_FIELDS_W = $bits(cmd_fields_t);

endpackage : dp_ctrl_pkg
`default_nettype wire

// File: rtl/load_reg.sv
`default_nettype none
// ============================================================================
// Module      : load_reg
// Description : Load-enabled register primitive with asynchronous
//               active-low clear.
// Ports       : clk, reset_n, en (load enable), d (next value), q (stored)
// Revision    : 1.0 - initial release
// ============================================================================
module load_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule : load_reg
`default_nettype wire

// File: rtl/datapath_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : datapath_sequencer
// Description : Moore-FSM controller for the lab datapath (8x16 register
//               file, A/B/C registers, shifter, ALU). Accepts one command
//               over valid/ready and drives all datapath strobes/selects.
// Ports       : clk, reset_n            - clock, async active-low reset
//               cmd_valid/cmd_ready     - command handshake
//               cmd_op/rd/rn/rm/alu/shift/imm - command fields
//               readnum, writenum       - register file addresses
//               write, loada, loadb, loadc, loads - datapath strobes
//               asel, bsel, vsel        - operand / writeback selects
//               alu_op, shift_op        - ALU / shifter selects
//               datapath_in             - immediate to writeback mux
//               done, err               - one-cycle completion / error pulses
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_sequencer
    import dp_ctrl_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [2:0]        cmd_rd,
    input  logic [2:0]        cmd_rn,
    input  logic [2:0]        cmd_rm,
    input  logic [1:0]        cmd_alu,
    input  logic [1:0]        cmd_shift,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [2:0]        readnum,
    output logic [2:0]        writenum,
    output logic              write,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic              vsel,
    output logic [1:0]        alu_op,
    output logic [1:0]        shift_op,
    output logic [DATA_W-1:0] datapath_in,
    output logic              done,
    output logic              err
);

    state_t           r_state;
    state_t           w_next;
    cmd_fields_t      w_cmd_in;
    cmd_fields_t      r_cmd;
    logic [DATA_W-1:0] r_imm;
    logic             w_accept;

    // Accept only in IDLE; valid in any other state is simply ignored
    assign w_accept = cmd_valid && (r_state == S_IDLE);

    assign w_cmd_in = '{op: cmd_op, rd: cmd_rd, rn: cmd_rn, rm: cmd_rm,
                        alu: cmd_alu, shift: cmd_shift};

    // Command capture: every later output is decoded from these copies
    load_reg #(.WIDTH(CMD_FIELDS_W)) u_cmd_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (w_accept),
        .d       (w_cmd_in),
        .q       (r_cmd)
    );

    load_reg #(.WIDTH(DATA_W)) u_imm_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (w_accept),
        .d       (cmd_imm),
        .q       (r_imm)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore output decode. Outputs depend only on r_state and
    // the captured command, so the async reset clears every strobe at once.
    always_comb begin
        w_next      = r_state;
        cmd_ready   = 1'b0;
        readnum     = 3'd0;
        writenum    = 3'd0;
        write       = 1'b0;
        loada       = 1'b0;
        loadb       = 1'b0;
        loadc       = 1'b0;
        loads       = 1'b0;
        asel        = 1'b0;
        bsel        = 1'b0;
        vsel        = VSEL_C;
        alu_op      = 2'd0;
        shift_op    = 2'd0;
        datapath_in = '0;
        done        = 1'b0;
        err         = 1'b0;

        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_MOV_IMM: w_next = S_WB_IMM;
                        OP_MOV:     w_next = S_LOAD_B;
                        OP_ALU,
                        OP_CMP:     w_next = S_LOAD_A;
                        default:    w_next = S_ERR;
                    endcase
                end
            end
            S_LOAD_A: begin
                readnum = r_cmd.rn;
                loada   = 1'b1;
                w_next  = S_LOAD_B;
            end
            S_LOAD_B: begin
                readnum  = r_cmd.rm;
                loadb    = 1'b1;
                shift_op = r_cmd.shift;
                w_next   = S_EXEC;
            end
            S_EXEC: begin
                alu_op   = r_cmd.alu;
                shift_op = r_cmd.shift;
                // MOV passes the shifted B operand through by zeroing A
                asel     = (r_cmd.op == OP_MOV);
                loads    = (r_cmd.op == OP_ALU) || (r_cmd.op == OP_CMP);
                loadc    = (r_cmd.op == OP_MOV) || (r_cmd.op == OP_ALU);
                w_next   = (r_cmd.op == OP_CMP) ? S_DONE : S_WB_C;
            end
            S_WB_C: begin
                writenum = r_cmd.rd;
                vsel     = VSEL_C;
                write    = 1'b1;
                w_next   = S_DONE;
            end
            S_WB_IMM: begin
                writenum    = r_cmd.rd;
                vsel        = VSEL_IMM;
                datapath_in = r_imm;
                write       = 1'b1;
                w_next      = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            S_ERR: begin
                err    = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule : datapath_sequencer
`default_nettype wire

// File: tb/tb_datapath_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_datapath_sequencer
// Description : Directed self-checking bench for datapath_sequencer with a
//               small behavioural model of the lab datapath driven by the
//               DUT strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_sequencer;

    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op, cmd_rd, cmd_rn, cmd_rm;
    logic [1:0]        cmd_alu, cmd_shift;
    logic [DATA_W-1:0] cmd_imm;
    logic [2:0]        readnum, writenum;
    logic              write, loada, loadb, loadc, loads;
    logic              asel, bsel, vsel;
    logic [1:0]        alu_op, shift_op;
    logic [DATA_W-1:0] datapath_in;
    logic              done, err;

    always #5 clk = ~clk;

    datapath_sequencer #(.DATA_W(DATA_W)) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_rd      (cmd_rd),
        .cmd_rn      (cmd_rn),
        .cmd_rm      (cmd_rm),
        .cmd_alu     (cmd_alu),
        .cmd_shift   (cmd_shift),
        .cmd_imm     (cmd_imm),
        .readnum     (readnum),
        .writenum    (writenum),
        .write       (write),
        .loada       (loada),
        .loadb       (loadb),
        .loadc       (loadc),
        .loads       (loads),
        .asel        (asel),
        .bsel        (bsel),
        .vsel        (vsel),
        .alu_op      (alu_op),
        .shift_op    (shift_op),
        .datapath_in (datapath_in),
        .done        (done),
        .err         (err)
    );

    // ------------------------------------------------------------------
    // Behavioural datapath
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] regs [8];
    logic [DATA_W-1:0] ra, rb, rc;
    logic              rz;
    logic [DATA_W-1:0] w_ain, w_bin, w_alu;

    function automatic logic [DATA_W-1:0] shf(input logic [DATA_W-1:0] b, input logic [1:0] s);
        case (s)
            2'd1:    return {b[DATA_W-2:0], 1'b0};
            2'd2:    return {1'b0, b[DATA_W-1:1]};
            2'd3:    return {b[DATA_W-1], b[DATA_W-1:1]};
            default: return b;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] alu_f(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                                input logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return ~b;
        endcase
    endfunction

    always_comb begin
        w_ain = asel ? '0 : ra;
        w_bin = shf(rb, shift_op);
        w_alu = alu_f(w_ain, w_bin, alu_op);
    end

    int n_accept = 0;
    int n_write  = 0;

    always @(posedge clk) begin
        if (loada) ra <= regs[readnum];
        if (loadb) rb <= regs[readnum];
        if (loadc) rc <= w_alu;
        if (loads) rz <= (w_alu == '0);
        if (write) begin
            regs[writenum] <= vsel ? datapath_in : rc;
            n_write        <= n_write + 1;
        end
        if (cmd_valid && cmd_ready) n_accept <= n_accept + 1;
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {loada,loadb,loadc,loads,write,asel,vsel,done,err,cmd_ready}
    localparam logic [9:0] T_LA    = 10'b1000000000;
    localparam logic [9:0] T_LB    = 10'b0100000000;
    localparam logic [9:0] T_ALUEX = 10'b0011000000;
    localparam logic [9:0] T_MOVEX = 10'b0010010000;
    localparam logic [9:0] T_CMPEX = 10'b0001000000;
    localparam logic [9:0] T_WBC   = 10'b0000100000;
    localparam logic [9:0] T_WBIMM = 10'b0000101000;
    localparam logic [9:0] T_DONE  = 10'b0000000100;
    localparam logic [9:0] T_ERR   = 10'b0000000010;
    localparam logic [9:0] T_IDLE  = 10'b0000000001;

    logic [9:0]        tr     [1:10];
    logic [2:0]        tr_rn  [1:10];
    logic [2:0]        tr_wn  [1:10];
    logic [DATA_W-1:0] tr_din [1:10];
    logic [1:0]        tr_sh  [1:10];

    function automatic logic [9:0] strobes();
        return {loada, loadb, loadc, loads, write, asel, vsel, done, err, cmd_ready};
    endfunction

    // Present a command, wait for the accept edge, then scramble the inputs
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rn,
                         input logic [2:0] rm, input logic [1:0] alu, input logic [1:0] sh,
                         input logic [DATA_W-1:0] imm);
        int t = 0;
        while (!cmd_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) check("ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm;
        cmd_alu = alu; cmd_shift = sh; cmd_imm = imm;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 3'd7; cmd_rd = ~rd; cmd_rn = ~rn; cmd_rm = ~rm;
        cmd_alu = ~alu; cmd_shift = ~sh; cmd_imm = ~imm;
    endtask

    task automatic trace(input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            tr[k]     = strobes();
            tr_rn[k]  = readnum;
            tr_wn[k]  = writenum;
            tr_din[k] = datapath_in;
            tr_sh[k]  = shift_op;
        end
    endtask

    int a0, w0;

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = '0; cmd_rd = '0; cmd_rn = '0; cmd_rm = '0;
        cmd_alu = '0; cmd_shift = '0; cmd_imm = '0;

        // Reset state
        #12;
        check("rst_strobes", 32'(strobes()), 32'(T_IDLE));
        check("rst_addr", {26'd0, readnum, writenum}, 32'd0);
        check("rst_din", 32'(datapath_in), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // MOV_IMM R3 <= 0x00A5
        issue(3'd0, 3'd3, 3'd0, 3'd0, 2'd0, 2'd0, 16'h00A5);
        trace(3);
        check("movi_c1", 32'(tr[1]), 32'(T_WBIMM));
        check("movi_wn", 32'(tr_wn[1]), 32'd3);
        check("movi_din", 32'(tr_din[1]), 32'h00A5);
        check("movi_c2", 32'(tr[2]), 32'(T_DONE));
        check("movi_din_off", 32'(tr_din[2]), 32'd0);
        check("movi_c3", 32'(tr[3]), 32'(T_IDLE));
        check("movi_r3", 32'(regs[3]), 32'h00A5);

        // Preload R1=7, R2=5
        issue(3'd0, 3'd1, 3'd0, 3'd0, 2'd0, 2'd0, 16'd7);
        trace(3);
        issue(3'd0, 3'd2, 3'd0, 3'd0, 2'd0, 2'd0, 16'd5);
        trace(3);
        check("pre_r1", 32'(regs[1]), 32'd7);
        check("pre_r2", 32'(regs[2]), 32'd5);

        // ALU ADD R4 = R1 + R2
        issue(3'd2, 3'd4, 3'd1, 3'd2, 2'd0, 2'd0, 16'h0);
        trace(6);
        check("add_c1", 32'(tr[1]), 32'(T_LA));
        check("add_rn", 32'(tr_rn[1]), 32'd1);
        check("add_c2", 32'(tr[2]), 32'(T_LB));
        check("add_rm", 32'(tr_rn[2]), 32'd2);
        check("add_c3", 32'(tr[3]), 32'(T_ALUEX));
        check("add_c4", 32'(tr[4]), 32'(T_WBC));
        check("add_wn", 32'(tr_wn[4]), 32'd4);
        check("add_c5", 32'(tr[5]), 32'(T_DONE));
        check("add_c6", 32'(tr[6]), 32'(T_IDLE));
        check("add_r4", 32'(regs[4]), 32'd12);

        // MOV R6 = R2 << 1
        issue(3'd1, 3'd6, 3'd0, 3'd2, 2'd0, 2'd1, 16'h0);
        trace(5);
        check("mov_c1", 32'(tr[1]), 32'(T_LB));
        check("mov_sh", 32'(tr_sh[1]), 32'd1);
        check("mov_c2", 32'(tr[2]), 32'(T_MOVEX));
        check("mov_c3", 32'(tr[3]), 32'(T_WBC));
        check("mov_c4", 32'(tr[4]), 32'(T_DONE));
        check("mov_c5", 32'(tr[5]), 32'(T_IDLE));
        check("mov_r6", 32'(regs[6]), 32'd10);

        // CMP R1 - R1
        w0 = n_write;
        issue(3'd3, 3'd5, 3'd1, 3'd1, 2'd1, 2'd0, 16'h0);
        trace(5);
        check("cmp_c1", 32'(tr[1]), 32'(T_LA));
        check("cmp_c2", 32'(tr[2]), 32'(T_LB));
        check("cmp_c3", 32'(tr[3]), 32'(T_CMPEX));
        check("cmp_c4", 32'(tr[4]), 32'(T_DONE));
        check("cmp_c5", 32'(tr[5]), 32'(T_IDLE));
        check("cmp_nowrite", 32'(n_write - w0), 32'd0);
        check("cmp_z", 32'(rz), 32'd1);

        // Illegal opcode
        w0 = n_write;
        issue(3'd6, 3'd2, 3'd1, 3'd1, 2'd0, 2'd0, 16'hFFFF);
        trace(2);
        check("ill_c1", 32'(tr[1]), 32'(T_ERR));
        check("ill_addr", {26'd0, tr_rn[1], tr_wn[1]}, 32'd0);
        check("ill_c2", 32'(tr[2]), 32'(T_IDLE));
        check("ill_nowrite", 32'(n_write - w0), 32'd0);

        // Busy: ALU SUB R7 = R1 - R2 with a MOV_IMM held valid throughout
        issue(3'd2, 3'd7, 3'd1, 3'd2, 2'd1, 2'd0, 16'h0);
        a0 = n_accept;
        cmd_op = 3'd0; cmd_rd = 3'd5; cmd_imm = 16'h1234;
        cmd_valid = 1'b1;
        trace(6);
        check("busy_c3", 32'(tr[3]), 32'(T_ALUEX));
        check("busy_c5", 32'(tr[5]), 32'(T_DONE));
        check("busy_c6", 32'(tr[6]), 32'(T_IDLE));
        check("busy_noacc", 32'(n_accept - a0), 32'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        trace(3);
        check("held_c1", 32'(tr[1]), 32'(T_WBIMM));
        check("held_wn", 32'(tr_wn[1]), 32'd5);
        check("held_c2", 32'(tr[2]), 32'(T_DONE));
        check("held_once", 32'(n_accept - a0), 32'd1);
        check("busy_r7", 32'(regs[7]), 32'd2);
        check("held_r5", 32'(regs[5]), 32'h1234);

        // Reset during EXEC of ALU targeting R3
        w0 = n_write;
        issue(3'd2, 3'd3, 3'd1, 3'd2, 2'd0, 2'd0, 16'h0);
        trace(3);
        check("rmid_exec", 32'(tr[3]), 32'(T_ALUEX));
        #2;
        reset_n = 1'b0;
        #1;
        check("rmid_strobes", 32'(strobes()), 32'(T_IDLE));
        check("rmid_addr", {26'd0, readnum, writenum}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        trace(3);
        check("rmid_idle", 32'(tr[3]), 32'(T_IDLE));
        check("rmid_nowrite", 32'(n_write - w0), 32'd0);
        check("rmid_r3", 32'(regs[3]), 32'h00A5);
        check("bsel_zero", 32'(bsel), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_datapath_sequencer
`default_nettype wire
